// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared widths, opcodes, control words and stage types
package control_pkg;
   localparam int WB_W   = 2;
   localparam int MEM_W  = 3;
   localparam int CALC_W = 4;

   localparam int OP_NOP    = 0;
   localparam int OP_ALU    = 1;
   localparam int OP_LOAD   = 2;
   localparam int OP_STORE  = 3;
   localparam int OP_BRANCH = 4;
   localparam int OP_MUL    = 5;

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [MEM_W-1:0]  mem;
      logic [CALC_W-1:0] calc;
   } ctrl_word_t;

   localparam ctrl_word_t CW_NOP    = '{wb: 2'b00, mem: 3'b000, calc: 4'b0000};
   localparam ctrl_word_t CW_ALU    = '{wb: 2'b01, mem: 3'b000, calc: 4'b0001};
   localparam ctrl_word_t CW_LOAD   = '{wb: 2'b11, mem: 3'b001, calc: 4'b0010};
   localparam ctrl_word_t CW_STORE  = '{wb: 2'b00, mem: 3'b010, calc: 4'b0010};
   localparam ctrl_word_t CW_BRANCH = '{wb: 2'b00, mem: 3'b000, calc: 4'b0100};
   localparam ctrl_word_t CW_MUL    = '{wb: 2'b01, mem: 3'b000, calc: 4'b1000};

   typedef struct packed {
      ctrl_word_t ctrl;
      logic       illegal;
   } ex_stage_t;

   typedef struct packed {
      logic [WB_W-1:0]  wb;
      logic [MEM_W-1:0] mem;
   } mem_stage_t;

   typedef struct packed {
      logic [WB_W-1:0] wb;
   } wb_stage_t;

   localparam ex_stage_t EX_BUBBLE = '0;
endpackage

// File: rtl/pipeline_control_if.sv
// rtl/pipeline_control_if.sv - decode-side handshake and stage control outputs
interface pipeline_control_if #(parameter int OP_W = 6);
   import control_pkg::*;

   logic [OP_W-1:0]   opCode;
   logic              instrValid;
   logic              stall;
   logic              flush;
   logic              busy;
   logic [CALC_W-1:0] exCalculationControl;
   logic [MEM_W-1:0]  memMemAccessControl;
   logic [WB_W-1:0]   memWriteBackControl;
   logic [WB_W-1:0]   wbWriteBackControl;
   logic              exIllegalOp;

   modport master (
      output opCode, instrValid, stall, flush,
      input  busy, exCalculationControl, memMemAccessControl,
             memWriteBackControl, wbWriteBackControl, exIllegalOp
   );

   modport slave (
      input  opCode, instrValid, stall, flush,
      output busy, exCalculationControl, memMemAccessControl,
             memWriteBackControl, wbWriteBackControl, exIllegalOp
   );
endinterface

// File: rtl/control_decoder.sv
// rtl/control_decoder.sv - opcode to control word, flags undefined opcodes
module control_decoder
   import control_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] op_code,
   output ctrl_word_t      ctrl,
   output logic            illegal
);
   always_comb begin
      ctrl    = CW_NOP;
      illegal = 1'b0;
      case (op_code)
         OP_W'(OP_NOP):    ctrl = CW_NOP;
         OP_W'(OP_ALU):    ctrl = CW_ALU;
         OP_W'(OP_LOAD):   ctrl = CW_LOAD;
         OP_W'(OP_STORE):  ctrl = CW_STORE;
         OP_W'(OP_BRANCH): ctrl = CW_BRANCH;
         OP_W'(OP_MUL):    ctrl = CW_MUL;
         default:          illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - EX/MEM/WB control pipeline; CONTROL_MULTICYCLE_EN enables multi-cycle MUL
module pipeline_control
   import control_pkg::*;
#(
   parameter int OP_W       = 6,
   parameter int MUL_CYCLES = 4
) (
   input logic               clk,
   input logic               reset,
   pipeline_control_if.slave bus
);
`ifdef CONTROL_MULTICYCLE_EN
   localparam bit MULTICYCLE = 1'b1;
`else
   localparam bit MULTICYCLE = 1'b0;
`endif

   ctrl_word_t dec_ctrl;
   logic       dec_illegal;
   logic       accept;
   logic       hold;
   ex_stage_t  ex_q, ex_d;
   mem_stage_t mem_q, mem_d;
   wb_stage_t  wb_q;

   control_decoder #(.OP_W(OP_W)) u_decoder (
      .op_code (bus.opCode),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   assign accept = bus.instrValid && !bus.stall && !bus.flush;

   // While a multiply holds EX, decode inputs are ignored and MEM receives bubbles.
   always_comb begin
      ex_d  = EX_BUBBLE;
      mem_d = '{wb: ex_q.ctrl.wb, mem: ex_q.ctrl.mem};
      if (hold) begin
         ex_d  = ex_q;
         mem_d = '0;
      end else if (accept) begin
         ex_d.ctrl    = dec_ctrl;
         ex_d.illegal = dec_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q.wb <= mem_q.wb;
      end
   end

   // A MUL is recognised by its unique calc field; the counter counts remaining extra EX cycles.
   generate
      if (MULTICYCLE && MUL_CYCLES > 1) begin : g_mul_cnt
         localparam int CNT_W = $clog2(MUL_CYCLES);
         logic [CNT_W-1:0] cnt_q;

         assign hold = (ex_q.ctrl.calc == CW_MUL.calc) && (cnt_q != '0);

         always_ff @(posedge clk) begin
            if (reset)
               cnt_q <= '0;
            else if (hold)
               cnt_q <= cnt_q - CNT_W'(1);
            else if (ex_d.ctrl.calc == CW_MUL.calc)
               cnt_q <= CNT_W'(MUL_CYCLES - 1);
            else
               cnt_q <= '0;
         end
      end else begin : g_no_cnt
         assign hold = 1'b0;
      end
   endgenerate

   assign bus.busy                 = hold;
   assign bus.exCalculationControl = ex_q.ctrl.calc;
   assign bus.exIllegalOp          = ex_q.illegal;
   assign bus.memMemAccessControl  = mem_q.mem;
   assign bus.memWriteBackControl  = mem_q.wb;
   assign bus.wbWriteBackControl   = wb_q.wb;
endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - directed stimulus, per-cycle model compare plus literal pins
module tb_pipeline_control;
   localparam int OP_W       = 6;
   localparam int MUL_CYCLES = 4;
`ifdef CONTROL_MULTICYCLE_EN
   localparam bit MC = 1'b1;
`else
   localparam bit MC = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   pipeline_control_if #(.OP_W(OP_W)) bus ();

   pipeline_control #(.OP_W(OP_W), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Control word table as {wb, mem, calc}
   function automatic logic [8:0] cw(input int op);
      case (op)
         1:       return 9'b01_000_0001;
         2:       return 9'b11_001_0010;
         3:       return 9'b00_010_0010;
         4:       return 9'b00_000_0100;
         5:       return 9'b01_000_1000;
         default: return 9'b00_000_0000;
      endcase
   endfunction

   // Model: opcode in EX, extra EX cycles still owed, and the words in MEM/WB
   int         m_ex_op   = 0;
   int         m_left    = 0;
   logic [1:0] m_mem_wb  = '0;
   logic [2:0] m_mem_mem = '0;
   logic [1:0] m_wb      = '0;

   always @(posedge clk) begin
      logic [8:0] e;
      if (reset) begin
         m_ex_op = 0; m_left = 0; m_mem_wb = '0; m_mem_mem = '0; m_wb = '0;
      end else begin
         m_wb = m_mem_wb;
         if (m_left > 0) begin
            m_left    = m_left - 1;
            m_mem_wb  = '0;
            m_mem_mem = '0;
         end else begin
            e         = cw(m_ex_op);
            m_mem_wb  = e[8:7];
            m_mem_mem = e[6:4];
            if (bus.instrValid && !bus.stall && !bus.flush) begin
               m_ex_op = int'(bus.opCode);
               m_left  = (MC && m_ex_op == 5) ? MUL_CYCLES - 1 : 0;
            end else begin
               m_ex_op = 0;
               m_left  = 0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (chk_en) begin
         e = cw(m_ex_op);
         check("busy", 32'(bus.busy), 32'(m_left > 0));
         check("ex_calc", 32'(bus.exCalculationControl), 32'(e[3:0]));
         check("ex_illegal", 32'(bus.exIllegalOp), 32'(m_ex_op > 5));
         check("mem_mem", 32'(bus.memMemAccessControl), 32'(m_mem_mem));
         check("mem_wb", 32'(bus.memWriteBackControl), 32'(m_mem_wb));
         check("wb_wb", 32'(bus.wbWriteBackControl), 32'(m_wb));
      end
   end

   task automatic cyc(input logic [5:0] op, input bit v, input bit s, input bit f, input bit r);
      reset          = r;
      bus.opCode     = op;
      bus.instrValid = v;
      bus.stall      = s;
      bus.flush      = f;
      @(negedge clk);
      #1;
   endtask

   initial begin
      int nb;
      bus.opCode = '0; bus.instrValid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
      reset = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk_en = 1'b1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_calc", 32'(bus.exCalculationControl), 32'd0);
      check("rst_wb", 32'(bus.wbWriteBackControl), 32'd0);
      cyc(6'd0, 0, 0, 0, 0);

      // ALU, LOAD, STORE back to back
      cyc(6'd1, 1, 0, 0, 0); check("t1_calc_alu", 32'(bus.exCalculationControl), 32'b0001);
      cyc(6'd2, 1, 0, 0, 0); check("t1_calc_load", 32'(bus.exCalculationControl), 32'b0010);
      cyc(6'd3, 1, 0, 0, 0); check("t1_calc_store", 32'(bus.exCalculationControl), 32'b0010);
      check("t1_wb_alu", 32'(bus.wbWriteBackControl), 32'b01);
      cyc(6'd0, 0, 0, 0, 0); check("t1_wb_load", 32'(bus.wbWriteBackControl), 32'b11);
      cyc(6'd0, 0, 0, 0, 0); check("t1_wb_store", 32'(bus.wbWriteBackControl), 32'b00);

      // Stall bubble behind an ALU op
      cyc(6'd1, 1, 0, 0, 0);
      cyc(6'd2, 1, 1, 0, 0); check("t2_stall_calc", 32'(bus.exCalculationControl), 32'd0);
      check("t2_alu_mem", 32'(bus.memWriteBackControl), 32'b01);
      cyc(6'd0, 0, 0, 0, 0); check("t2_alu_wb", 32'(bus.wbWriteBackControl), 32'b01);
      check("t2_bubble_mem", 32'(bus.memWriteBackControl), 32'd0);
      cyc(6'd0, 0, 0, 0, 0); check("t2_bubble_wb", 32'(bus.wbWriteBackControl), 32'd0);
      cyc(6'd1, 1, 0, 1, 0); check("t2_flush_calc", 32'(bus.exCalculationControl), 32'd0);
      cyc(6'd0, 0, 0, 0, 0);
      cyc(6'd0, 0, 0, 0, 0);

      // Multiply with flush/new opcodes offered while busy
      cyc(6'd5, 1, 0, 0, 0); check("t3_mul_calc", 32'(bus.exCalculationControl), 32'b1000);
      nb = int'(bus.busy);
      cyc(6'd3, 1, 0, 1, 0); nb += int'(bus.busy);
      cyc(6'd2, 1, 0, 1, 0); nb += int'(bus.busy);
      check("t3_wb_n3", 32'(bus.wbWriteBackControl), MC ? 32'd0 : 32'b01);
      cyc(6'd0, 0, 0, 0, 0);
      check("t3_busy_n4", 32'(bus.busy), 32'd0);
      check("t3_ex_n4", 32'(bus.exCalculationControl), MC ? 32'b1000 : 32'd0);
      check("t3_busy_count", 32'(nb), MC ? 32'd3 : 32'd0);
      cyc(6'd0, 0, 0, 0, 0); check("t3_mem_n5", 32'(bus.memWriteBackControl), MC ? 32'b01 : 32'd0);
      cyc(6'd0, 0, 0, 0, 0); check("t3_wb_n6", 32'(bus.wbWriteBackControl), MC ? 32'b01 : 32'd0);

      // Undefined opcode
      cyc(6'h3F, 1, 0, 0, 0); check("t4_illegal", 32'(bus.exIllegalOp), 32'd1);
      check("t4_calc", 32'(bus.exCalculationControl), 32'd0);
      cyc(6'd0, 0, 0, 0, 0); check("t4_illegal_clr", 32'(bus.exIllegalOp), 32'd0);
      check("t4_mem", 32'(bus.memMemAccessControl), 32'd0);
      cyc(6'd0, 0, 0, 0, 0); check("t4_wb", 32'(bus.wbWriteBackControl), 32'd0);

      // Reset during the second busy cycle
      cyc(6'd5, 1, 0, 0, 0);
      cyc(6'd0, 0, 0, 0, 0); check("t5_busy2", 32'(bus.busy), 32'(MC));
      cyc(6'd0, 0, 0, 0, 1); check("t5_rst_busy", 32'(bus.busy), 32'd0);
      check("t5_rst_calc", 32'(bus.exCalculationControl), 32'd0);
      for (int i = 0; i < 5; i++) cyc(6'd0, 0, 0, 0, 0);
      check("t5_no_wb", 32'(bus.wbWriteBackControl), 32'd0);

      // Branch / load / store memory fields
      cyc(6'd4, 1, 0, 0, 0); check("t6_branch_calc", 32'(bus.exCalculationControl), 32'b0100);
      cyc(6'd2, 1, 0, 0, 0); check("t6_branch_mem", 32'(bus.memMemAccessControl), 32'b000);
      cyc(6'd3, 1, 0, 0, 0); check("t6_load_mem", 32'(bus.memMemAccessControl), 32'b001);
      cyc(6'd0, 0, 0, 0, 0); check("t6_store_mem", 32'(bus.memMemAccessControl), 32'b010);

      // Back-to-back multiplies, then an ALU op straight after
      for (int i = 0; i < 9; i++) cyc(6'd5, 1, 0, 0, 0);
      cyc(6'd1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(6'd0, 0, 0, 0, 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipeline_control.md
# pipeline_control

Pipelined control unit: decodes each issued opcode into write-back, memory-access and calculation control words, then carries them through the EX, MEM and WB pipeline registers. It supports decode-stage stall and flush bubbles and multi-cycle multiply occupancy of EX with a `busy` back-pressure signal. It sits between the instruction-decode stage and the datapath, replacing the purely combinational `Control` decoder.

## Interface
Parameters:
- `OP_W`, 6, opcode width; ≥ 3.
- `MUL_CYCLES`, 4, EX occupancy of a multiply in cycles; ≥ 1.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opCode`  in  OP_W  opcode presented by decode.
- `instrValid`  in  1  `opCode` is a real instruction this cycle.
- `stall`  in  1  hazard unit: insert a bubble into EX this cycle.
- `flush`  in  1  branch taken: kill the instruction in decode.
- `busy`  out  1  EX is held by a multiply; decode must hold its instruction.
- `exCalculationControl`  out  4  EX-stage calculation control.
- `memMemAccessControl`  out  3  MEM-stage memory-access control.
- `memWriteBackControl`  out  2  write-back word carried in MEM (for forwarding).
- `wbWriteBackControl`  out  2  WB-stage write-back control.
- `exIllegalOp`  out  1  instruction in EX had an undefined opcode.

## Operation
- Decode, giving wb/mem/calc: 0 NOP 00/000/0000; 1 ALU 01/000/0001; 2 LOAD 11/001/0010; 3 STORE 00/010/0010; 4 BRANCH 00/000/0100; 5 MUL 01/000/1000.
- Any other value decodes to NOP with `exIllegalOp`=1 while it is in EX.
- A bubble is the all-zero control word with the illegal flag cleared.
- EX loads a bubble when `instrValid`=0, `stall`=1 or `flush`=1; otherwise it loads the decoded word.
- Priority, highest first: `reset` > `busy` hold > `flush` = `stall` = `!instrValid`.
- MEM loads EX's wb/mem fields; WB loads MEM's wb field. Both advance every cycle.
- Multiply: on entering EX, a down-counter loads `MUL_CYCLES-1`.
- While the counter ≠ 0: EX holds its contents, the counter decrements, MEM loads a bubble, and all decode inputs (including `flush`) are ignored.
- `busy` = (EX holds MUL) && (counter ≠ 0), combinational from registers.
- A flush never kills a multiply already in EX.
- Reset: all stage registers, the counter and `exIllegalOp` go to 0, so every output is 0 including `busy`. Reset mid-multiply aborts it.

## Timing
- Non-multiply op accepted at edge N: EX control visible cycle N+1, MEM N+2, WB N+3.
- MUL with `MUL_CYCLES`=4 accepted at edge N:
  - in EX cycles N+1..N+4, with `busy` high N+1..N+3;
  - MEM at N+5, WB at N+6;
  - next instruction accepted at the edge ending N+4.
- `MUL_CYCLES`=1: a multiply behaves exactly like an ALU op and `busy` never rises.
- Back-to-back multiplies: the second enters EX the cycle after the first's final EX cycle.

## Configuration
- `CONTROL_MULTICYCLE_EN` defined: multi-cycle multiply as described.
- Not defined: the counter is removed, `busy` is tied 0, and MUL is single-cycle irrespective of `MUL_CYCLES`.

## Structure
- Shared package `control_pkg` holds:
  - widths `WB_W`=2, `MEM_W`=3, `CALC_W`=4;
  - opcode constants `OP_NOP`…`OP_MUL`;
  - the per-opcode control-word constants;
  - the packed stage-register struct types.
- One combinational sub-module, `control_decoder` (opcode → control word + illegal flag).
- Pipeline registers, counter and hold logic live in `pipeline_control`.

## Test plan
- Reset, then opcodes 1, 2, 3 on consecutive cycles with `instrValid`=1 → `exCalculationControl` 0001, 0010, 0010 at N+1..N+3; `wbWriteBackControl` 01, 11, 00 at N+3..N+5.
- `stall`=1 with opcode 2 → EX 0000 next cycle, and MEM/WB bubbles follow; the earlier instruction in MEM still reaches WB.
- Opcode 5, `MUL_CYCLES`=4 → `busy` high exactly 3 cycles; `flush`/new opcode during `busy` ignored; wb 01 at N+6.
- Opcode 6'h3F → `exIllegalOp`=1 for one cycle, all control words 0 downstream.
- `reset` asserted during the 2nd busy cycle → next cycle `busy`=0 and all outputs 0; the multiply never reaches WB.
- Build without `CONTROL_MULTICYCLE_EN`, opcode 5 → `busy` stays 0, wb 01 at N+3.
